// File: rtl/fetch_unit.sv
// Instruction fetch unit: in-order request issue, 2-entry response buffer, redirect flush/discard.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets yield a fault-marker entry and halt fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] rpc_q, rpc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  disc_q, disc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        halt_q, halt_d;
  entry_t      fifo_q [2];
  entry_t      fifo_d [2];

  logic [31:0] tgt;
  logic        misaligned;
  logic        pop, push, fire;
  logic [2:0]  load;
  logic [1:0]  wr_idx;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt        = redirect_pc_i;
  assign misaligned = |redirect_pc_i[1:0];
`else
  logic unused_pc_lsb;
  assign tgt           = {redirect_pc_i[31:2], 2'b00};
  assign misaligned    = 1'b0;
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
`endif

  assign instr_valid_o = (cnt_q != 2'd0);
  assign instr_o       = instr_valid_o ? fifo_q[0].instr : NOP;
  assign pc_o          = fifo_q[0].pc;
  assign misalign_o    = instr_valid_o & fifo_q[0].mis;

  // A same-cycle pop frees a slot, which keeps back-to-back fetch at full rate.
  assign pop         = instr_valid_o & instr_ready_i;
  assign load        = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop};
  assign imem_req_o  = (state_q != BOOT) && !halt_q && (load < 3'd2);
  assign imem_addr_o = fpc_q;
  assign fire        = imem_req_o & imem_gnt_i;
  assign push        = imem_rvalid_i && (disc_q == 2'd0);
  assign wr_idx      = cnt_q - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    fpc_d   = fire ? fpc_q + 32'd4 : fpc_q;
    rpc_d   = rpc_q;
    out_d   = out_q + {1'b0, fire} - {1'b0, imem_rvalid_i};
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    fifo_d  = fifo_q;

    if (redirect_i) begin
      // Everything still in flight after this edge, including a same-cycle grant, is discarded.
      cnt_d   = 2'd0;
      disc_d  = out_d;
      state_d = (out_d != 2'd0) ? DRAIN : RUN;
      fpc_d   = tgt;
      rpc_d   = tgt;
      halt_d  = 1'b0;
      if (misaligned) begin
        halt_d    = 1'b1;
        fifo_d[0] = '{instr: NOP, pc: tgt, mis: 1'b1};
        cnt_d     = 2'd1;
      end
    end else begin
      if (imem_rvalid_i && (disc_q != 2'd0))
        disc_d = disc_q - 2'd1;
      if (pop)
        fifo_d[0] = fifo_q[1];
      if (push) begin
        if (wr_idx == 2'd0)
          fifo_d[0] = '{instr: imem_rdata_i, pc: rpc_q, mis: 1'b0};
        else
          fifo_d[1] = '{instr: imem_rdata_i, pc: rpc_q, mis: 1'b0};
        rpc_d = rpc_q + 32'd4;
      end
      cnt_d = cnt_q - {1'b0, pop} + {1'b0, push};
      unique case (state_q)
        BOOT:       state_d = RUN;
        RUN, DRAIN: state_d = (disc_d != 2'd0) ? DRAIN : RUN;
        default:    state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++)
        fifo_q[i] <= '{instr: NOP, pc: RESET_PC, mis: 1'b0};
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a program-order reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i = 1'b0;
  logic        misalign_o;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_ready_i(instr_ready_i), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned xfer_cyc[$];
  logic [31:0] xfer_pc[$];
  int unsigned checks = 0, errors = 0;
  int unsigned cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] prev_addr = '0, mis_pc = '0, last_pc = '0;
  logic        prev_redir = 1'b0, prev_mis = 1'b0, prev_pend = 1'b0;
  logic        mis_pending = 1'b0, halted = 1'b0, last_req = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt, input logic gnt);
    logic        rv;
    int unsigned due;
    @(negedge clk_i);
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    imem_gnt_i    = gnt;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_data(mq[0].addr) : $urandom;
    #1;
    if (!instr_valid_o) check32("nop_idle", instr_o, NOP);
    if (prev_redir && !prev_mis) check32("valid_drop", {31'b0, instr_valid_o}, 32'd0);
    if (prev_pend) begin
      check32("req_hold", {31'b0, imem_req_o}, 32'd1);
      check32("addr_hold", imem_addr_o, prev_addr);
    end
    if (imem_req_o) check32("addr_align", {30'b0, imem_addr_o[1:0]}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (halted) check32("halt_no_req", {31'b0, imem_req_o}, 32'd0);
    if (halted && !mis_pending) check32("halt_no_valid", {31'b0, instr_valid_o}, 32'd0);
`endif
    if (instr_valid_o && rdy && !redir) begin
      if (mis_pending) begin
        check32("mis_pc", pc_o, mis_pc);
        check32("mis_instr", instr_o, NOP);
        check32("mis_flag", {31'b0, misalign_o}, 32'd1);
        mis_pending = 1'b0;
      end else begin
        check32("xfer_pc", pc_o, exp_pc);
        check32("xfer_instr", instr_o, mem_data(exp_pc));
        check32("xfer_mis", {31'b0, misalign_o}, 32'd0);
        xfer_cyc.push_back(cyc);
        xfer_pc.push_back(pc_o);
        exp_pc = exp_pc + 32'd4;
      end
    end
    prev_mis = 1'b0;
    if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        mis_pending = 1'b1;
        mis_pc      = tgt;
        halted      = 1'b1;
        prev_mis    = 1'b1;
      end else begin
        mis_pending = 1'b0;
        halted      = 1'b0;
        exp_pc      = {tgt[31:2], 2'b00};
      end
`else
      exp_pc = {tgt[31:2], 2'b00};
`endif
    end
    prev_redir = redir;
    prev_pend  = imem_req_o && !gnt && !redir;
    prev_addr  = imem_addr_o;
    last_req   = imem_req_o;
    last_pc    = pc_o;
    if (rv) void'(mq.pop_front());
    if (imem_req_o && gnt) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_addr_o, due: due});
    end
    cyc++;
  endtask

  initial begin
    int unsigned n0;
    logic [31:0] head_pc, tgt;
    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    check32("rst_req", {31'b0, imem_req_o}, 32'd0);
    check32("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check32("rst_mis", {31'b0, misalign_o}, 32'd0);
    check32("rst_pc", pc_o, RST_PC);
    check32("rst_instr", instr_o, NOP);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Streaming from RESET_PC with single-cycle memory
    repeat (8) step(1'b1, 1'b0, '0, 1'b1);
    check32("stream_count", {31'b0, xfer_cyc.size() >= 3}, 32'd1);
    if (xfer_cyc.size() >= 3) begin
      check32("first_pc", xfer_pc[0], RST_PC);
      check32("b2b_1", xfer_cyc[1] - xfer_cyc[0], 32'd1);
      check32("b2b_2", xfer_cyc[2] - xfer_cyc[1], 32'd1);
    end

    // Decode stall: buffer fills to exactly two entries, head holds
    head_pc = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (i == 3) head_pc = last_pc;
      if (i > 3) check32("stall_head", last_pc, head_pc);
    end
    check32("stall_req", {31'b0, last_req}, 32'd0);
    n0 = xfer_cyc.size();
    repeat (4) step(1'b1, 1'b0, '0, 1'b0);
    check32("stall_depth", xfer_cyc.size() - n0, 32'd2);

    // Redirect with two responses in flight
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && mq.size() != 2; i++) step(1'b1, 1'b0, '0, 1'b1);
    check32("inflight_wait", mq.size(), 32'd2);
    n0 = xfer_pc.size();
    step(1'b1, 1'b1, 32'h0000_0400, 1'b1);
    repeat (10) step(1'b1, 1'b0, '0, 1'b1);
    check32("redir_resumed", {31'b0, xfer_pc.size() > n0}, 32'd1);
    if (xfer_pc.size() > n0) check32("redir_first", xfer_pc[n0], 32'h0000_0400);

    // Misaligned redirect target
    lat_min = 1; lat_max = 1;
    n0 = xfer_pc.size();
    step(1'b1, 1'b1, 32'h0000_0402, 1'b1);
    repeat (10) step(1'b1, 1'b0, '0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    check32("mis_seen", {31'b0, mis_pending}, 32'd0);
    check32("mis_halt", {31'b0, last_req}, 32'd0);
    check32("mis_no_fetch", xfer_pc.size() - n0, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
`else
    check32("mis_resumed", {31'b0, xfer_pc.size() > n0}, 32'd1);
    if (xfer_pc.size() > n0) check32("mis_first", xfer_pc[n0], 32'h0000_0400);
`endif

    // Address wrap past the top of memory
    n0 = xfer_pc.size();
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (10) step(1'b1, 1'b0, '0, 1'b1);
    check32("wrap_count", {31'b0, xfer_pc.size() >= n0 + 4}, 32'd1);
    if (xfer_pc.size() >= n0 + 4) check32("wrap_pc", xfer_pc[n0 + 2], 32'h0000_0000);

    // Random traffic: stalls on both sides, variable latency, occasional redirects
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      logic rd;
      rd  = ($urandom_range(99, 0) < 3);
      tgt = $urandom;
      if ($urandom_range(3, 0) != 0) tgt[1:0] = 2'b00;
      step($urandom_range(99, 0) < 70, rd, tgt, $urandom_range(99, 0) < 60);
    end
    check32("random_progress", {31'b0, xfer_pc.size() > 100}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port imem_req_o, output, 1 bit: fetch request valid.
REQ-005 SHALL have port imem_addr_o, output, 32 bits: fetch word address; bits [1:0] are always 0.
REQ-006 SHALL have port imem_gnt_i, input, 1 bit: request accepted when high in the same cycle as imem_req_o.
REQ-007 SHALL have port imem_rvalid_i, input, 1 bit: response valid; responses arrive in order, at least 1 cycle after grant.
REQ-008 SHALL have port imem_rdata_i, input, 32 bits: response instruction word.
REQ-009 SHALL have port redirect_i, input, 1 bit: branch, jump or trap redirect.
REQ-010 SHALL have port redirect_pc_i, input, 32 bits: redirect target.
REQ-011 SHALL have port instr_valid_o, output, 1 bit: instruction available to decode and immediate generation.
REQ-012 SHALL have port instr_o, output, 32 bits: instruction word to decode.
REQ-013 SHALL have port pc_o, output, 32 bits: address of instr_o.
REQ-014 SHALL have port instr_ready_i, input, 1 bit: decode accepts; a transfer occurs when instr_valid_o and instr_ready_i are both high.
REQ-015 SHALL have port misalign_o, output, 1 bit: instr_o is a misaligned-target fault marker.

Function
REQ-016 SHALL keep a fetch PC (fpc) that advances by 4 on each granted request, wrapping from 32'hFFFF_FFFC to 0.
REQ-017 SHALL hold a 2-entry in-order buffer of {instr, pc, misalign}; instr_o, pc_o and misalign_o come from the head entry.
REQ-018 SHALL assert imem_req_o only when outstanding requests plus buffer occupancy is less than 2, so responses never overflow the buffer.
REQ-019 SHALL hold imem_req_o and imem_addr_o stable until granted, except when a redirect occurs.
REQ-020 SHALL allow a buffer push (rvalid) and a pop (transfer) in the same cycle when full; occupancy then stays unchanged.
REQ-021 SHALL, on redirect_i, in the same cycle: flush the buffer, drop instr_valid_o from the next cycle, set fpc to redirect_pc_i, and set a discard count equal to the responses still in flight.
REQ-022 SHALL not push responses while the discard count is nonzero; each such rvalid decrements the count.
REQ-023 SHALL give redirect_i priority over a same-cycle grant, rvalid or transfer; a grant in that cycle is counted as in flight and later discarded.
REQ-024 SHALL issue the first request at the redirect target no earlier than the cycle after redirect_i.
REQ-025 SHALL implement a state machine with three states:
  - BOOT (one cycle after reset release, no request), then to RUN.
  - RUN: normal operation.
  - DRAIN: discard count > 0. Requests are allowed; return to RUN when the count reaches 0.
  - redirect_i in any state enters DRAIN if responses are in flight, otherwise RUN.
REQ-026 SHALL present instr_o = 32'h0000_0013 (NOP) whenever instr_valid_o is low.

Reset
REQ-027 SHALL, while rst_i is high:
  - set fpc = RESET_PC, state = BOOT, buffer empty, outstanding and discard counts = 0;
  - drive imem_req_o = 0, instr_valid_o = 0, misalign_o = 0, pc_o = RESET_PC.
REQ-028 SHALL abandon any requests outstanding at reset; the memory is reset together with this block.

Configuration
REQ-029 SHALL, with FETCH_MISALIGN_TRAP_EN defined:
  - on redirect_pc_i[1:0] != 0, issue no request;
  - push one entry {NOP, redirect_pc_i, misalign=1};
  - halt fetch until the next redirect.
REQ-030 SHALL, without FETCH_MISALIGN_TRAP_EN, force redirect_pc_i[1:0] to 0 and tie misalign_o to 0.

Verification
REQ-031 Reset release with RESET_PC = 0x100, always-grant memory with 1-cycle latency, ready = 1: transfers pc 0x100, 0x104, 0x108 on consecutive cycles.
REQ-032 ready = 0 for 10 cycles: exactly 2 entries buffered, imem_req_o = 0, head pc_o stable.
REQ-033 redirect_i to 0x400 with 2 responses in flight: both responses dropped, next transfer is pc 0x400.
REQ-034 Full buffer with same-cycle rvalid and transfer: no data loss, order preserved.
REQ-035 Redirect to 0x402 with macro defined: one transfer with misalign_o = 1 and pc_o = 0x402, then no requests; without the macro, fetch proceeds from 0x400.
